// File: rtl/jpeg_tx_pkg.sv
// Shared types for the JPEG transmit frame buffer.
// Write/read FSM encodings and header length width.
package jpeg_tx_pkg;

  localparam int LEN_W = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    HDR_HI = 2'd0,
    HDR_LO = 2'd1,
    DATA   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/jpeg_tx_buffer_if.sv
// Encoder-side and SPI-side signal bundle of the frame buffer.
// master = encoder/host driver side, slave = buffer side.
interface jpeg_tx_buffer_if;
  import jpeg_tx_pkg::*;

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             flush;
  logic             mem_rd;
  logic [7:0]       mem_data;
  logic             frame_ready;
  logic [LEN_W-1:0] frame_len;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    output flush,
    output mem_rd,
    input  in_ready,
    input  mem_data,
    input  frame_ready,
    input  frame_len
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    input  flush,
    input  mem_rd,
    output in_ready,
    output mem_data,
    output frame_ready,
    output frame_len
  );

endinterface

// File: rtl/jpeg_tx_ram.sv
// Simple dual-port byte RAM with registered read port.
// Array is left unreset so it maps onto block RAM.
module jpeg_tx_ram #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/jpeg_tx_buffer.sv
// One-frame buffer between JPEG encoder and SPI slave.
// Serves a 2-byte big-endian length header, then the frame.
module jpeg_tx_buffer
  import jpeg_tx_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input logic             clk,
  input logic             reset_n,
  jpeg_tx_buffer_if.slave bus
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  wr_state_t        ws, ws_n;
  rd_state_t        rs, rs_n;
  logic [ADDR_W:0]  wr_ptr, wr_ptr_n;
  logic [ADDR_W:0]  rd_ptr, rd_ptr_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [7:0]       data_q, data_n;
  logic [7:0]       ram_q;
  logic             alive;
  logic             full;
  logic             wr_hs;
  logic             last_hs;
  logic             rd_go;
  logic             eof;
  logic             show;

  assign full         = wr_ptr[ADDR_W];
  assign bus.in_ready = alive && (ws == FILL) && !full;
  assign wr_hs        = bus.in_valid && bus.in_ready;
  assign last_hs      = wr_hs && bus.in_last;
  assign rd_go        = (ws == HOLD) && bus.mem_rd;
  // wr_ptr holds the byte count in HOLD; avoids the 64K length wrap
  assign eof          = rd_go && (rs == DATA)
                     && ((rd_ptr + ONE) == wr_ptr);
  assign show         = (ws == HOLD) && !eof;

  assign bus.frame_ready = (ws == HOLD);
  assign bus.frame_len   = len_q;
  assign bus.mem_data    = data_q;

  always_comb begin
    ws_n     = ws;
    rs_n     = rs;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    len_n    = len_q;
    data_n   = '0;
    if (bus.flush) begin
      ws_n     = FILL;
      rs_n     = HDR_HI;
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      len_n    = '0;
    end else begin
      if (wr_hs)
        wr_ptr_n = wr_ptr + ONE;
      if (last_hs) begin
        ws_n  = HOLD;
        rs_n  = HDR_HI;
        len_n = LEN_W'(wr_ptr + ONE);
      end
      if (rd_go) begin
        unique case (rs)
          HDR_HI:  rs_n = HDR_LO;
          HDR_LO:  rs_n = DATA;
          default: rd_ptr_n = rd_ptr + ONE;
        endcase
      end
      if (eof) begin
        ws_n     = FILL;
        rs_n     = HDR_HI;
        wr_ptr_n = '0;
        rd_ptr_n = '0;
      end
      // header byte appears on the same edge frame_ready rises
      unique case (1'b1)
        last_hs: data_n = len_n[LEN_W-1:8];
        show: begin
          unique case (rs)
            HDR_HI:  data_n = len_q[LEN_W-1:8];
            HDR_LO:  data_n = len_q[7:0];
            default: data_n = ram_q;
          endcase
        end
        default: data_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ws     <= FILL;
      rs     <= HDR_HI;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len_q  <= '0;
      data_q <= '0;
      alive  <= 1'b0;
    end else begin
      ws     <= ws_n;
      rs     <= rs_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      len_q  <= len_n;
      data_q <= data_n;
      alive  <= 1'b1;
    end
  end

  // read address follows the next pointer so RAM[0] is prefetched
  jpeg_tx_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_hs && !bus.flush),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(bus.in_data),
    .raddr(rd_ptr_n[ADDR_W-1:0]),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_jpeg_tx_buffer.sv
// Self-checking bench for jpeg_tx_buffer.
// Reference: expected stream = length header + bytes in write order.
module tb_jpeg_tx_buffer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] tx[$];
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];

  jpeg_tx_buffer_if b();
  jpeg_tx_buffer_if b4();

  jpeg_tx_buffer #(.ADDR_W(13)) dut (
    .clk(clk), .reset_n(reset_n), .bus(b.slave)
  );

  jpeg_tx_buffer #(.ADDR_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(b4.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp();
    int n;
    n = tx.size();
    exp_q.delete();
    exp_q.push_back(8'(n >> 8));
    exp_q.push_back(8'(n & 255));
    foreach (tx[i]) exp_q.push_back(tx[i]);
  endtask

  task automatic make_frame(input int n);
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
    build_exp();
  endtask

  task automatic send(input bit last, input bit gaps);
    for (int i = 0; i < tx.size(); i++) begin
      int w;
      if (gaps) begin
        b.in_valid = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
      end
      b.in_data  = tx[i];
      b.in_valid = 1'b1;
      b.in_last  = last && (i == tx.size() - 1);
      w = 0;
      while (!b.in_ready && w < 200) begin
        tick();
        w++;
      end
      if (!b.in_ready) begin
        total++;
        bad++;
        $display("FAIL send_timeout byte=%0d in_ready=%b want=1", i, b.in_ready);
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
        return;
      end
      tick();
    end
    b.in_valid = 1'b0;
    b.in_last  = 1'b0;
  endtask

  task automatic drain(input int n);
    rx.delete();
    for (int k = 0; k < n; k++) begin
      rx.push_back(b.mem_data);
      b.mem_rd = 1'b1;
      tick();
      b.mem_rd = 1'b0;
      tick();
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++;
    if (b.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_ready_hold got=%b want=0", b.in_ready);
    end
    reset_n = 1'b1;
    tick();
    make_frame(5);
    send(1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (b.in_ready !== 1'b0 || b.frame_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_async got=%b%b want=00", b.in_ready, b.frame_ready);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    total++;
    if (b.in_ready !== 1'b1 || b.frame_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_flags got=%b%b want=10", b.in_ready, b.frame_ready);
    end
    total++;
    if (b.mem_data !== 8'h00 || b.frame_len !== 16'h0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h want=00/0000", b.mem_data, b.frame_len);
    end
    total++;
    if (b4.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_ready4 got=%b want=1", b4.in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      b.mem_rd = 1'b1;
      tick();
      b.mem_rd = 1'b0;
      tick();
      total++;
      if (b.mem_data !== 8'h00 || b.frame_ready !== 1'b0) begin
        bad++;
        $display("FAIL rst_rd%0d got=%h want=00", k, b.mem_data);
      end
    end
  endtask

  task automatic test_basic();
    tx = '{8'hA1, 8'hB2, 8'hC3};
    build_exp();
    send(1'b1, 1'b0);
    total++;
    if (b.frame_ready !== 1'b1 || b.frame_len !== 16'd3) begin
      bad++;
      $display("FAIL basic_ready got=%b/%0d want=1/3", b.frame_ready, b.frame_len);
    end
    total++;
    if (b.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold_ready got=%b want=0", b.in_ready);
    end
    drain(5);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rx[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL basic_byte%0d got=%h want=%h", i, rx[i], exp_q[i]);
      end
    end
    total++;
    if (b.mem_data !== 8'h00 || b.frame_ready !== 1'b0 || b.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_end got=%h/%b/%b want=00/0/1",
               b.mem_data, b.frame_ready, b.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    make_frame(6);
    send(1'b1, 1'b0);
    b.mem_rd = 1'b1;
    tick();
    tick();
    b.mem_rd = 1'b0;
    tick();
    total++;
    if (b.mem_data !== tx[0]) begin
      bad++;
      $display("FAIL b2b_hdr got=%h want=%h", b.mem_data, tx[0]);
    end
    b.mem_rd = 1'b1;
    tick();
    tick();
    b.mem_rd = 1'b0;
    tick();
    total++;
    if (b.mem_data !== tx[2]) begin
      bad++;
      $display("FAIL b2b_data got=%h want=%h", b.mem_data, tx[2]);
    end
    drain(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx[i] !== tx[i+2]) begin
        bad++;
        $display("FAIL b2b_byte%0d got=%h want=%h", i, rx[i], tx[i+2]);
      end
    end
    total++;
    if (b.frame_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got=%b want=0", b.frame_ready);
    end
  endtask

  task automatic test_backpressure();
    make_frame(4);
    send(1'b1, 1'b1);
    b.in_data  = 8'h5A;
    b.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (b.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_ready%0d got=%b want=0", k, b.in_ready);
      end
      tick();
    end
    b.in_valid = 1'b0;
    total++;
    if (b.frame_len !== 16'd4) begin
      bad++;
      $display("FAIL bp_len got=%0d want=4", b.frame_len);
    end
    drain(exp_q.size());
    foreach (exp_q[i]) begin
      total++;
      if (rx[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL bp_byte%0d got=%h want=%h", i, rx[i], exp_q[i]);
      end
    end
    make_frame(3);
    send(1'b1, 1'b1);
    drain(exp_q.size());
    foreach (exp_q[i]) begin
      total++;
      if (rx[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL bp_next%0d got=%h want=%h", i, rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_full_stall();
    b4.in_valid = 1'b1;
    b4.in_last  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      b4.in_data = 8'($urandom);
      total++;
      if (b4.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL full_accept%0d got=%b want=1", k, b4.in_ready);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (b4.in_ready !== 1'b0 || b4.frame_ready !== 1'b0) begin
        bad++;
        $display("FAIL full_stall%0d got=%b%b want=00", k, b4.in_ready, b4.frame_ready);
      end
      tick();
    end
    b4.flush = 1'b1;
    tick();
    b4.flush    = 1'b0;
    b4.in_valid = 1'b0;
    total++;
    if (b4.in_ready !== 1'b1 || b4.frame_ready !== 1'b0 || b4.mem_data !== 8'h00) begin
      bad++;
      $display("FAIL full_flush got=%b%b/%h want=10/00",
               b4.in_ready, b4.frame_ready, b4.mem_data);
    end
    make_frame(16);
    for (int k = 0; k < 16; k++) begin
      b4.in_data  = tx[k];
      b4.in_valid = 1'b1;
      b4.in_last  = (k == 15);
      tick();
    end
    b4.in_valid = 1'b0;
    b4.in_last  = 1'b0;
    total++;
    if (b4.frame_ready !== 1'b1 || b4.frame_len !== 16'd16) begin
      bad++;
      $display("FAIL full_len got=%b/%0d want=1/16", b4.frame_ready, b4.frame_len);
    end
    foreach (exp_q[i]) begin
      total++;
      if (b4.mem_data !== exp_q[i]) begin
        bad++;
        $display("FAIL full_byte%0d got=%h want=%h", i, b4.mem_data, exp_q[i]);
      end
      b4.mem_rd = 1'b1;
      tick();
      b4.mem_rd = 1'b0;
      tick();
    end
    total++;
    if (b4.frame_ready !== 1'b0 || b4.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_end got=%b%b want=01", b4.frame_ready, b4.in_ready);
    end
  endtask

  task automatic test_flush_drain();
    make_frame(10);
    send(1'b1, 1'b1);
    drain(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL fl_byte%0d got=%h want=%h", i, rx[i], exp_q[i]);
      end
    end
    b.flush  = 1'b1;
    b.mem_rd = 1'b1;
    tick();
    b.flush  = 1'b0;
    b.mem_rd = 1'b0;
    total++;
    if (b.frame_ready !== 1'b0 || b.mem_data !== 8'h00 || b.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL fl_state got=%b/%h/%b want=0/00/1",
               b.frame_ready, b.mem_data, b.in_ready);
    end
    tick();
    total++;
    if (b.mem_data !== 8'h00) begin
      bad++;
      $display("FAIL fl_quiet got=%h want=00", b.mem_data);
    end
    b.in_data  = 8'h5A;
    b.in_valid = 1'b1;
    b.in_last  = 1'b1;
    b.flush    = 1'b1;
    tick();
    b.in_valid = 1'b0;
    b.in_last  = 1'b0;
    b.flush    = 1'b0;
    total++;
    if (b.frame_ready !== 1'b0) begin
      bad++;
      $display("FAIL fl_prio got=%b want=0", b.frame_ready);
    end
    make_frame($urandom_range(5, 20));
    send(1'b1, 1'b1);
    total++;
    if (b.frame_len !== 16'(tx.size())) begin
      bad++;
      $display("FAIL fl_len got=%0d want=%0d", b.frame_len, tx.size());
    end
    drain(exp_q.size());
    foreach (exp_q[i]) begin
      total++;
      if (rx[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL fl_next%0d got=%h want=%h", i, rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_length_header();
    make_frame(300);
    send(1'b1, 1'b1);
    total++;
    if (b.frame_len !== 16'd300 || b.mem_data !== 8'h01) begin
      bad++;
      $display("FAIL len_hdr got=%0d/%h want=300/01", b.frame_len, b.mem_data);
    end
    b.mem_rd = 1'b1;
    tick();
    b.mem_rd = 1'b0;
    total++;
    if (b.mem_data !== 8'h01) begin
      bad++;
      $display("FAIL len_lat1 got=%h want=01", b.mem_data);
    end
    tick();
    total++;
    if (b.mem_data !== 8'h2C) begin
      bad++;
      $display("FAIL len_lat2 got=%h want=2c", b.mem_data);
    end
    drain(301);
    for (int i = 0; i < 301; i++) begin
      total++;
      if (rx[i] !== exp_q[i+1]) begin
        bad++;
        $display("FAIL len_byte%0d got=%h want=%h", i, rx[i], exp_q[i+1]);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      make_frame($urandom_range(1, 80));
      send(1'b1, 1'b1);
      total++;
      if (b.frame_ready !== 1'b1 || b.frame_len !== 16'(tx.size())) begin
        bad++;
        $display("FAIL rnd%0d_len got=%b/%0d want=1/%0d",
                 f, b.frame_ready, b.frame_len, tx.size());
      end
      drain(exp_q.size());
      foreach (exp_q[i]) begin
        total++;
        if (rx[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rnd%0d_byte%0d got=%h want=%h", f, i, rx[i], exp_q[i]);
        end
      end
      total++;
      if (b.frame_ready !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d_end got=%b want=0", f, b.frame_ready);
      end
    end
  endtask

  initial begin
    b.in_data   = 8'h00;
    b.in_valid  = 1'b0;
    b.in_last   = 1'b0;
    b.flush     = 1'b0;
    b.mem_rd    = 1'b0;
    b4.in_data  = 8'h00;
    b4.in_valid = 1'b0;
    b4.in_last  = 1'b0;
    b4.flush    = 1'b0;
    b4.mem_rd   = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_full_stall();
    test_flush_drain();
    test_length_header();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jpeg_tx_buffer.md
# jpeg_tx_buffer

Frame buffer between the JPEG encoder output byte stream and the SPI slave read port. Stores one complete compressed frame in on-chip RAM, then serves it byte-by-byte to the SPI slave on each `mem_rd` pulse, prefixed by a 2-byte big-endian length header. It asserts `frame_ready` to the ESP32 host while a frame is available. It blocks the encoder until the host has drained the frame.

## Interface
- `ADDR_W`, default 13: RAM address width; capacity is 2^ADDR_W bytes; legal range 4..16.
- `clk`  in  1: single system clock; all logic is on the rising edge.
- `reset_n`  in  1: reset is asynchronous and active-low.
- `in_data`  in  8: encoder output byte.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_last`  in  1: qualifies `in_data` as the final byte of the frame.
- `in_ready`  out  1: the buffer accepts a byte this cycle.
- `flush`  in  1: single-cycle synchronous abort; discards the buffer contents.
- `mem_rd`  in  1: single-cycle pop request from the SPI slave.
- `mem_data`  out  8: registered byte currently presented to the SPI slave.
- `frame_ready`  out  1: a complete frame is stored and not yet fully read.
- `frame_len`  out  16: byte count of the stored frame; valid while `frame_ready`=1.

## Operation
- Reset values: `in_ready`=0 during reset, then 1 from the first cycle after reset. `mem_data`=8'h00, `frame_ready`=0, `frame_len`=0. Pointers are 0 and the state is FILL.
- The write FSM has two states, FILL and HOLD.
  - FILL: `in_ready` = !full, where full means wr_ptr count = 2^ADDR_W.
  - In FILL, when `in_valid` and `in_ready` are both 1: write `in_data` at wr_ptr, then increment wr_ptr.
  - If `in_last` is also 1: latch `frame_len` = wr_ptr+1 (16-bit, zero-extended) and go to HOLD.
  - HOLD: `in_ready`=0 and `frame_ready`=1.
- A full buffer without `in_last` stalls the encoder indefinitely. No bytes are dropped; `flush` is the only exit.
- The read FSM (active only in HOLD) has states HDR_HI, HDR_LO, DATA, and is in HDR_HI on entry to HOLD.
  - HDR_HI: `mem_data` = `frame_len[15:8]`. On `mem_rd`, go to HDR_LO.
  - HDR_LO: `mem_data` = `frame_len[7:0]`. On `mem_rd`, go to DATA.
  - DATA: `mem_data` = RAM[rd_ptr]. Each `mem_rd` increments rd_ptr.
  - A `mem_rd` that consumes the byte at rd_ptr = `frame_len`-1 ends the frame. Then: pointers reset to 0, `frame_ready` drops, `mem_data` becomes 8'h00, and the write FSM returns to FILL.
- Outside HOLD, `mem_rd` is ignored and `mem_data` holds 8'h00.
- `flush` has priority over all other events in the same cycle, including write, last, and read. It returns the block to reset values, except that `in_ready` follows FILL rules on the next cycle.
- Arithmetic: wr_ptr and rd_ptr are ADDR_W+1 bits wide to distinguish full from empty. `frame_len` is 16 bits. When ADDR_W=16, a full 65536-byte frame sets `frame_len`=0. This wrap is allowed and documented: the host treats 0 as 65536.

## Timing
- Write acceptance costs zero bubbles: one byte per cycle while `in_ready`=1.
- `frame_ready` rises 1 cycle after the `in_last` handshake. At that same edge, `mem_data` already shows `frame_len[15:8]`.
- Read latency: `mem_data` shows the next byte exactly 2 cycles after the `mem_rd` pulse. This is 1 cycle for the synchronous RAM read plus 1 output register.
- On the HDR_LO→DATA transition, RAM[0] is prefetched, so the 2-cycle latency also holds for the first data byte.
- `mem_rd` pulses are separated by at least 8 SPI bit times. This is far more than 2 cycles, so back-to-back `mem_rd` need not be supported. The bench shall still not hang if `mem_rd` arrives on consecutive cycles: the second pulse is honoured with the same latency.
- `in_ready` returns to 1 one cycle after the final-byte `mem_rd`.

## Structure
- Shared package `jpeg_tx_pkg`:
  - write-state encodings FILL and HOLD;
  - read-state encodings HDR_HI, HDR_LO, DATA;
  - `LEN_W`=16.
- Sub-module `jpeg_tx_ram`: simple dual-port RAM, 8×2^ADDR_W, with one write port and one registered read port on the same `clk`. It must infer EBR/BRAM and has no reset on the array.
- Top-level: write FSM, read FSM, pointers, and the `mem_data` output mux/register.

## Test plan
- Reset: hold `reset_n`=0 mid-frame, then release. Expect `in_ready`=1, `frame_ready`=0, `mem_data`=00, and 3 `mem_rd` pulses each yielding 00.
- Basic frame: write A1, B2, C3 with `in_last` on C3. Expect `frame_ready`=1 and `frame_len`=3. Five `mem_rd` pulses yield 00, 03, A1, B2, C3 (each sampled 2 cycles after its pulse). Then expect `mem_data`=00, `frame_ready`=0, `in_ready`=1.
- Backpressure: while in HOLD, drive `in_valid`=1 with 5A. Expect `in_ready`=0 and the byte not stored. The next frame begins at address 0.
- Full stall: with ADDR_W=4, write 16 bytes without `in_last`. Expect `in_ready`=0 on the 17th cycle. Then `flush` restores `in_ready`=1 with an empty buffer.
- Flush mid-drain: for a 10-byte frame, after 4 `mem_rd` pulses assert `flush` together with `mem_rd`. Expect `frame_ready`=0 and `mem_data`=00 next cycle, and the next frame's header reports its own length.
- Length header: a 300-byte frame (ADDR_W=13) reads header 01, 2C, followed by all 300 bytes in write order.
